// File: rtl/operand2_pipe_unit.sv
// ---------------------------------------------------------------------------
// operand2_pipe_unit
//
// Purpose
//   EX-stage operand2 selector with a one-deep valid/ready output register.
//   Picks operand2 from PB, HI, LO, PC or one of four immediate extensions.
//   Owns the architectural HI/LO registers. Interlocks HI/LO reads while a
//   mult/div is in flight, so N never carries a stale HI/LO value.
//
// Optional feature macro
//   OP2_HILO_BYPASS_EN
//     Defined:   a HI/LO read that coincides with md_done (and no md_start)
//                is accepted in that cycle. It captures hi_in/lo_in directly.
//     Undefined: the same read stalls for one cycle. It is then accepted from
//                the freshly written HI/LO register.
//
// Parameters
//   DATA_W    datapath width (must be >= IMM_W+2)
//   IMM_W     immediate field width
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous reset, active low
//   in_valid   in   1       request present on PB/PC/imm/S
//   in_ready   out  1       request accepted when in_valid & in_ready
//   PB         in   DATA_W  register-file port B
//   PC         in   DATA_W  program counter
//   imm        in   IMM_W   instruction immediate
//   S          in   3       operand select
//   md_start   in   1       mult/div issued; HI/LO become pending
//   md_done    in   1       mult/div result valid on hi_in/lo_in
//   hi_in      in   DATA_W  new HI value
//   lo_in      in   DATA_W  new LO value
//   out_valid  out  1       N holds a result
//   out_ready  in   1       consumer takes N when out_valid & out_ready
//   N          out  DATA_W  selected operand2
//   hilo_busy  out  1       HI/LO pending flag
// ---------------------------------------------------------------------------
module operand2_pipe_unit #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] PB,
    input  logic [DATA_W-1:0] PC,
    input  logic [IMM_W-1:0]  imm,
    input  logic [2:0]        S,
    input  logic              md_start,
    input  logic              md_done,
    input  logic [DATA_W-1:0] hi_in,
    input  logic [DATA_W-1:0] lo_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] N,
    output logic              hilo_busy
);

    localparam int EXT_W = DATA_W - IMM_W;

    localparam logic [2:0] SEL_PB   = 3'b000;
    localparam logic [2:0] SEL_HI   = 3'b001;
    localparam logic [2:0] SEL_LO   = 3'b010;
    localparam logic [2:0] SEL_PC   = 3'b011;
    localparam logic [2:0] SEL_SEXT = 3'b100;
    localparam logic [2:0] SEL_LUI  = 3'b101;
    localparam logic [2:0] SEL_ZEXT = 3'b110;
    localparam logic [2:0] SEL_BOFS = 3'b111;

    // Architectural state
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              busy_q, busy_d;

    // Output register
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] n_q, n_d;

    // Datapath intermediates
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_lui;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] imm_bofs;
    logic [DATA_W-1:0] hi_src;
    logic [DATA_W-1:0] lo_src;
    logic [DATA_W-1:0] sel_val;
    logic              hilo_read;
    logic              bypass_ok;
    logic              hilo_stall;
    logic              accept;

    // -----------------------------------------------------------------------
    // Immediate extensions
    // -----------------------------------------------------------------------
    assign imm_sext = {{EXT_W{imm[IMM_W-1]}}, imm};
    assign imm_lui  = {imm, {EXT_W{1'b0}}};
    assign imm_zext = {{EXT_W{1'b0}}, imm};
    // Branch offset: the sign-extended immediate is scaled by 4.
    // The top two bits fall off, which matches the full-width shift.
    assign imm_bofs = {{(EXT_W-2){imm[IMM_W-1]}}, imm, 2'b00};

    // -----------------------------------------------------------------------
    // HI/LO source. When md_done arrives, hi_in/lo_in are the newest values.
    // A read that is accepted in that same cycle must see them. The register
    // only updates at the end of the cycle.
    //
    // If busy is set, the read only gets here through the bypass path. If
    // busy is clear, md_done is an unsolicited write.
    // -----------------------------------------------------------------------
    assign hi_src = md_done ? hi_in : hi_q;
    assign lo_src = md_done ? lo_in : lo_q;

    always_comb begin
        sel_val = PB;
        unique case (S)
            SEL_PB:   sel_val = PB;
            SEL_HI:   sel_val = hi_src;
            SEL_LO:   sel_val = lo_src;
            SEL_PC:   sel_val = PC;
            SEL_SEXT: sel_val = imm_sext;
            SEL_LUI:  sel_val = imm_lui;
            SEL_ZEXT: sel_val = imm_zext;
            SEL_BOFS: sel_val = imm_bofs;
            default:  sel_val = PB;
        endcase
    end

    // -----------------------------------------------------------------------
    // Interlock
    // -----------------------------------------------------------------------
    assign hilo_read = (S == SEL_HI) || (S == SEL_LO);

`ifdef OP2_HILO_BYPASS_EN
    // A completing mult/div with no new one issued behind it: the result on
    // hi_in/lo_in is final and can be forwarded straight into N.
    assign bypass_ok = md_done & ~md_start;
`else
    assign bypass_ok = 1'b0;
`endif

    assign hilo_stall = in_valid & hilo_read & busy_q & ~bypass_ok;
    assign in_ready   = (~out_valid_q | out_ready) & ~hilo_stall;
    assign accept     = in_valid & in_ready;

    // -----------------------------------------------------------------------
    // Next state
    // -----------------------------------------------------------------------
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        busy_d = busy_q;

        if (md_done) begin
            hi_d   = hi_in;
            lo_d   = lo_in;
            busy_d = 1'b0;
        end
        // A new issue wins over a completion in the same cycle. HI/LO stay
        // pending for the newly issued operation.
        if (md_start) begin
            busy_d = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        n_d         = n_q;

        if (accept) begin
            // Covers both a fill of an empty slot and an accept while draining.
            out_valid_d = 1'b1;
            n_d         = sel_val;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q        <= '0;
            lo_q        <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            n_q         <= '0;
        end else begin
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            n_q         <= n_d;
        end
    end

    assign out_valid = out_valid_q;
    assign N         = n_q;
    assign hilo_busy = busy_q;

endmodule

// File: tb/tb_operand2_pipe_unit.sv
module tb_operand2_pipe_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] PB;
    logic [31:0] PC;
    logic [15:0] imm;
    logic [2:0]  S;
    logic        md_start;
    logic        md_done;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] N;
    logic        hilo_busy;

    int errors;
    int checks;

    operand2_pipe_unit #(.DATA_W(32), .IMM_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .PB        (PB),
        .PC        (PC),
        .imm       (imm),
        .S         (S),
        .md_start  (md_start),
        .md_done   (md_done),
        .hi_in     (hi_in),
        .lo_in     (lo_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .N         (N),
        .hilo_busy (hilo_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] sweep_exp [8];

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        PB        = '0;
        PC        = '0;
        imm       = '0;
        S         = 3'b000;
        md_start  = 1'b0;
        md_done   = 1'b0;
        hi_in     = '0;
        lo_in     = '0;
        out_ready = 1'b1;

        // ---------------- reset state ----------------
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_N",         N,              32'd0);
        check("rst_busy",      32'(hilo_busy), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b1;
        step();

        // Load HI/LO with md_done while not busy (must still write)
        md_done = 1'b1;
        hi_in   = 32'h11111111;
        lo_in   = 32'h22222222;
        step();
        md_done = 1'b0;
        hi_in   = 32'h0;
        lo_in   = 32'h0;
        check("done_unbusy_busy", 32'(hilo_busy), 32'd0);

        // ---------------- select sweep ----------------
        sweep_exp[0] = 32'h22354678;
        sweep_exp[1] = 32'h11111111;
        sweep_exp[2] = 32'h22222222;
        sweep_exp[3] = 32'hFEDCBA98;
        sweep_exp[4] = 32'hFFFF8001;
        sweep_exp[5] = 32'h80010000;
        sweep_exp[6] = 32'h00008001;
        sweep_exp[7] = 32'hFFFE0004;
        PB       = 32'h22354678;
        PC       = 32'hFEDCBA98;
        imm      = 16'h8001;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            S = 3'(i);
            step();
            check($sformatf("sweep_S%0d_N", i), N, sweep_exp[i]);
            check($sformatf("sweep_S%0d_vld", i), 32'(out_valid), 32'd1);
        end

        // ---------------- LUI ----------------
        imm = 16'h6C44;
        S   = 3'b101;
        step();
        check("lui_N", N, 32'h6C440000);
        in_valid = 1'b0;
        step();
        check("lui_drained", 32'(out_valid), 32'd0);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        S         = 3'b000;
        PB        = 32'hA5A50001;
        step();
        check("bp_first_vld", 32'(out_valid), 32'd1);
        check("bp_first_N",   N, 32'hA5A50001);
        PB = 32'hA5A50002;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
            step();
            check($sformatf("bp_hold_N_%0d", i), N, 32'hA5A50001);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        check("bp_second_N",   N, 32'hA5A50002);
        check("bp_second_vld", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        step();
        check("bp_drained", 32'(out_valid), 32'd0);

        // ---------------- interlock ----------------
        md_start = 1'b1;
        step();
        md_start = 1'b0;
        check("il_busy_set", 32'(hilo_busy), 32'd1);
        // Non-HI/LO selects are not stalled by busy
        in_valid = 1'b1;
        S        = 3'b011;
        #1;
        check("il_pc_not_stalled", 32'(in_ready), 32'd1);
        step();
        check("il_pc_N", N, 32'hFEDCBA98);
        S = 3'b001;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("il_stall_%0d", i), 32'(in_ready), 32'd0);
            step();
            check($sformatf("il_no_out_%0d", i), 32'(out_valid), 32'd0);
        end
        md_done = 1'b1;
        hi_in   = 32'hABCDEF01;
        lo_in   = 32'h12345678;
        #1;
`ifdef OP2_HILO_BYPASS_EN
        check("il_bypass_ready", 32'(in_ready), 32'd1);
        step();
        md_done = 1'b0;
        hi_in   = 32'h0;
        lo_in   = 32'h0;
`else
        check("il_done_stall", 32'(in_ready), 32'd0);
        step();
        md_done = 1'b0;
        hi_in   = 32'h0;
        lo_in   = 32'h0;
        #1;
        check("il_after_ready", 32'(in_ready), 32'd1);
        step();
`endif
        check("il_hi_N",   N, 32'hABCDEF01);
        check("il_hi_vld", 32'(out_valid), 32'd1);
        check("il_busy_clr", 32'(hilo_busy), 32'd0);
        S = 3'b010;
        step();
        check("il_lo_N", N, 32'h12345678);
        in_valid = 1'b0;
        step();

        // ---------------- start+done / double start ----------------
        md_start = 1'b1;
        md_done  = 1'b1;
        hi_in    = 32'h0BAD0001;
        step();
        md_done  = 1'b0;
        check("sd_busy_kept", 32'(hilo_busy), 32'd1);
        step();
        md_start = 1'b0;
        check("ss_busy_kept", 32'(hilo_busy), 32'd1);
        md_done = 1'b1;
        hi_in   = 32'h0BAD0002;
        step();
        md_done = 1'b0;
        check("ss_busy_clr", 32'(hilo_busy), 32'd0);

        // ---------------- reset mid-stream ----------------
        md_start = 1'b1;
        step();
        md_start  = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        S         = 3'b000;
        PB        = 32'h5A5A5A5A;
        step();
        in_valid = 1'b0;
        check("mr_pre_vld",  32'(out_valid), 32'd1);
        check("mr_pre_busy", 32'(hilo_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_vld",  32'(out_valid), 32'd0);
        check("mr_N",    N, 32'd0);
        check("mr_busy", 32'(hilo_busy), 32'd0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        S         = 3'b001;
        #1;
        check("mr_hi_ready", 32'(in_ready), 32'd1);
        step();
        check("mr_HI_zero", N, 32'd0);
        check("mr_HI_vld", 32'(out_valid), 32'd1);
        S = 3'b010;
        step();
        check("mr_LO_zero", N, 32'd0);
        in_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
